// File: rtl/sevenseg_capture.sv
// sevenseg_capture: reads back a multiplexed active-low seven-segment bus.
// Each stable strobe dwell is decoded to a hex nibble and collected into a
// frame, which is handed out through a valid/ready handshake.
module sevenseg_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   out_value,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned CNT_W = ($clog2(STABLE_CYCLES) > 0) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [SEG_W-1:0]  seg_meta, seg_sync, seg_prev;
  logic [DIGITS-1:0] an_meta, an_sync, an_prev;
  logic [CNT_W-1:0]  cnt;
  logic              arm;
  logic [DIGITS-1:0] mask;
  logic [VAL_W-1:0]  collect_val;
  logic [DIGITS-1:0] collect_err;

  logic              changed;
  logic [DIGITS-1:0] strobe;
  logic              one_low;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        dig_nib;
  logic              dig_err;
  logic              accept;
  logic [VAL_W-1:0]  frame_val;
  logic [DIGITS-1:0] frame_err;
  logic [DIGITS-1:0] mask_new;
  logic              complete;

  state_t state, state_next;
  logic   load, drop;

  // Inverse of the hex-to-segment encoder; returns {err, nibble}.
  function automatic logic [4:0] decode(input logic [SEG_W-1:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  // Two-flop synchronizers plus a one-cycle history for change detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_meta <= '1;
      seg_sync <= '1;
      seg_prev <= '1;
      an_meta  <= '1;
      an_sync  <= '1;
      an_prev  <= '1;
    end else begin
      seg_meta <= seg;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      an_meta  <= an;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
    end
  end

  // Strobe legality and selected digit index.
  always_comb begin
    changed = ({an_sync, seg_sync} != {an_prev, seg_prev});
    strobe  = ~an_sync;
    one_low = (strobe != '0) && ((strobe & (strobe - DIGITS'(1))) == '0);
    idx     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (strobe[i]) idx = IDX_W'(i);
    end
  end

  // Acceptance and frame assembly with the incoming digit merged in.
  always_comb begin
    {dig_err, dig_nib} = decode(seg_sync);
    // !changed keeps a stale saturated count from accepting a fresh dwell early.
    accept    = one_low && arm && !changed && (cnt == CNT_MAX);
    frame_val = collect_val;
    frame_err = collect_err;
    frame_val[{idx, 2'b00} +: 4] = dig_nib;
    frame_err[idx]               = dig_err;
    mask_new  = mask | (DIGITS'(1) << idx);
    complete  = accept && (mask_new == '1);
  end

  // Stability counter, arm flag and collect slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      arm         <= 1'b1;
      mask        <= '0;
      collect_val <= '0;
      collect_err <= '0;
    end else begin
      if (changed) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (changed) begin
        arm <= 1'b1;
      end else if (accept) begin
        arm <= 1'b0;
      end
      if (accept) begin
        collect_val <= frame_val;
        collect_err <= frame_err;
        mask        <= complete ? '0 : mask_new;
      end
    end
  end

  // Output state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output next-state: load, hand off, or drop on collision.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      S_EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (complete) begin
          if (out_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (out_ready) begin
          state_next = S_EMPTY;
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // Registered output frame, valid and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_value <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_value <= frame_val;
        out_err   <= frame_err;
      end
      out_valid <= (state_next == S_FULL);
      overflow  <= drop;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: frame table plus multi-cycle corner cases.
`timescale 1ns/1ps
module tb_sevenseg_capture;

  localparam int unsigned DIGITS        = 4;
  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned NVEC          = 7;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] JUNK  = 7'b1010101;

  typedef struct packed {
    logic [27:0] pats;   // {digit3, digit2, digit1, digit0}
    logic [15:0] value;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] out_value;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int ovf_pulses = 0;
  int ovf0;
  frame_t vec [NVEC];

  sevenseg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .out_value (out_value),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Count overflow pulses away from the active edge.
  always @(negedge clk) if (overflow === 1'b1) ovf_pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_digit(input int i, input logic [6:0] p, input int cycles);
    an  = ~(4'(1) << i);
    seg = p;
    repeat (cycles) tick();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, " valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec[0] = '{pats: {S3, S2, S1, S0},    value: 16'h3210, err: 4'b0000};
    vec[1] = '{pats: {S7, S6, S5, S4},    value: 16'h7654, err: 4'b0000};
    vec[2] = '{pats: {SB, SA, S9, S8},    value: 16'hBA98, err: 4'b0000};
    vec[3] = '{pats: {SF, SE, SD, SC},    value: 16'hFEDC, err: 4'b0000};
    vec[4] = '{pats: {SC, SD, SE, SF},    value: 16'hCDEF, err: 4'b0000};
    vec[5] = '{pats: {S4, BLANK, S2, S1}, value: 16'h4021, err: 4'b0100};
    vec[6] = '{pats: {S0, SA, S5, JUNK},  value: 16'h0A50, err: 4'b0001};

    rst_n = 1'b0; an = '1; seg = BLANK; out_ready = 1'b0;
    repeat (3) tick();
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset value", 32'(out_value), 32'd0);
    check("reset err", 32'(out_err), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame with completion latency.
    drive_digit(0, S1, 10);
    drive_digit(1, S2, 10);
    drive_digit(2, S3, 10);
    drive_digit(3, S4, 6);
    check("basic early valid", 32'(out_valid), 32'd0);
    tick();
    check("basic valid edge", 32'(out_valid), 32'd1);
    check("basic value", 32'(out_value), 32'h4321);
    check("basic err", 32'(out_err), 32'd0);
    repeat (3) tick();
    handshake("basic");

    // Table of frames: full hex coverage and illegal patterns.
    for (int v = 0; v < NVEC; v++) begin
      for (int d = 0; d < 4; d++) drive_digit(d, vec[v].pats[7*d +: 7], 10);
      wait_valid($sformatf("vec%0d", v), 20);
      check($sformatf("vec%0d value", v), 32'(out_value), 32'(vec[v].value));
      check($sformatf("vec%0d err", v), 32'(out_err), 32'(vec[v].err));
      handshake($sformatf("vec%0d", v));
    end
    check("table overflow", 32'(ovf_pulses), 32'd0);

    // Short strobe glitch on digit 1 is ignored until a full dwell.
    drive_digit(0, S5, 10);
    drive_digit(2, S7, 10);
    drive_digit(3, S8, 10);
    drive_digit(1, S6, 3);
    an = '1; seg = BLANK;
    repeat (12) tick();
    check("glitch no frame", 32'(out_valid), 32'd0);
    drive_digit(1, S6, 10);
    check("glitch frame valid", 32'(out_valid), 32'd1);
    check("glitch value", 32'(out_value), 32'h8765);
    handshake("glitch");

    // Blanking and multi-low strobes neither accept nor disturb the mask.
    drive_digit(0, S9, 10);
    drive_digit(1, SA, 10);
    an = 4'b1111; seg = SB;
    repeat (20) tick();
    an = 4'b1100; seg = S7;
    repeat (20) tick();
    check("illegal strobe no frame", 32'(out_valid), 32'd0);
    drive_digit(2, SB, 10);
    drive_digit(3, SC, 10);
    check("illegal strobe valid", 32'(out_valid), 32'd1);
    check("illegal strobe value", 32'(out_value), 32'hCBA9);
    check("illegal strobe err", 32'(out_err), 32'd0);
    handshake("illegal strobe");

    // Two frames without ready: first kept, one overflow pulse.
    ovf0 = ovf_pulses;
    for (int d = 0; d < 4; d++) drive_digit(d, S1, 10);
    for (int d = 0; d < 4; d++) drive_digit(d, S2, 10);
    check("overflow valid", 32'(out_valid), 32'd1);
    check("overflow kept frame", 32'(out_value), 32'h1111);
    check("overflow pulses", 32'(ovf_pulses - ovf0), 32'd1);

    // Ready raised exactly on the completing cycle: new frame replaces old.
    for (int d = 0; d < 3; d++) drive_digit(d, S3, 10);
    drive_digit(3, S3, 6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dual valid", 32'(out_valid), 32'd1);
    check("dual value", 32'(out_value), 32'h3333);
    repeat (3) tick();
    check("dual held", 32'(out_value), 32'h3333);
    check("dual no overflow", 32'(ovf_pulses - ovf0), 32'd1);
    handshake("dual");

    // Reset with a held frame and a half-collected frame.
    for (int d = 0; d < 4; d++) drive_digit(d, S5, 10);
    check("pre-reset valid", 32'(out_valid), 32'd1);
    drive_digit(0, S1, 10);
    drive_digit(1, S2, 10);
    rst_n = 1'b0; an = '1; seg = BLANK;
    tick();
    check("mid reset valid", 32'(out_valid), 32'd0);
    check("mid reset value", 32'(out_value), 32'd0);
    check("mid reset err", 32'(out_err), 32'd0);
    check("mid reset overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    drive_digit(2, S8, 10);
    drive_digit(3, S9, 10);
    check("post reset partial", 32'(out_valid), 32'd0);
    drive_digit(0, S6, 10);
    check("post reset partial2", 32'(out_valid), 32'd0);
    drive_digit(1, S7, 10);
    check("post reset valid", 32'(out_valid), 32'd1);
    check("post reset value", 32'(out_value), 32'h9876);
    handshake("post reset");
    repeat (20) tick();
    check("post reset single frame", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
